// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the banked dual-requester scratchpad SRAM.
package sram_pkg;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  // Index width for a one-of-n select; a single bank still needs a 1-bit signal.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bank_bits(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int unsigned row_w(input int unsigned bank_depth);
    return sel_w(bank_depth);
  endfunction

  // Word-interleaved map: the low address bits pick the bank.
  function automatic int unsigned bank_idx(input logic [31:0] addr, input int unsigned num_banks);
    return addr & (num_banks - 1);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One single-port SRAM bank with per-byte write enables and a registered read.
module sram_bank import sram_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 256,
  localparam int ROW_W = row_w(DEPTH),
  localparam int BE_W  = WORD_W / 8
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Array is deliberately not reset; the read register only moves on reads.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (en_i && !we_i) rdata_q <= mem[row_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_banked_dp.sv
// Banked, dual-requester scratchpad SRAM: bank decode, round-robin conflict
// arbiter, grant steering into the banks and registered read-data return.
module sram_banked_dp import sram_pkg::*; #(
  parameter int WORD_W     = 32,
  parameter int BANK_DEPTH = 256,
  parameter int NUM_BANKS  = 4,
  localparam int ADDR_W    = $clog2(BANK_DEPTH * NUM_BANKS),
  localparam int BE_W      = WORD_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WORD_W-1:0] a_wdata,
  input  logic [BE_W-1:0]   a_be,
  output logic              a_rvalid,
  output logic [WORD_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WORD_W-1:0] b_wdata,
  input  logic [BE_W-1:0]   b_be,
  output logic              b_rvalid,
  output logic [WORD_W-1:0] b_rdata
);

  localparam int BANK_W    = sel_w(NUM_BANKS);
  localparam int BANK_BITS = bank_bits(NUM_BANKS);
  localparam int ROW_W     = row_w(BANK_DEPTH);

  logic [BANK_W-1:0] a_bank, b_bank;
  logic [ROW_W-1:0]  a_row, b_row;
  logic              conflict, a_fire, b_fire;
  port_e             rr_q, rr_d;

  assign a_bank = BANK_W'(bank_idx(32'(a_addr), NUM_BANKS));
  assign b_bank = BANK_W'(bank_idx(32'(b_addr), NUM_BANKS));
  assign a_row  = ROW_W'(a_addr >> BANK_BITS);
  assign b_row  = ROW_W'(b_addr >> BANK_BITS);

  assign conflict = a_valid && b_valid && (a_bank == b_bank);
  assign a_ready  = !rst && (!conflict || rr_q == PORT_A);
  assign b_ready  = !rst && (!conflict || rr_q == PORT_B);
  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;

  // Pointer hands priority to the loser so a stalled port wins next time.
  always_comb begin
    rr_d = rr_q;
    if (conflict) rr_d = (rr_q == PORT_A) ? PORT_B : PORT_A;
  end

  logic [NUM_BANKS-1:0] bank_en, bank_we;
  logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
  logic [WORD_W-1:0]    bank_wdata [NUM_BANKS];
  logic [BE_W-1:0]      bank_be    [NUM_BANKS];
  logic [WORD_W-1:0]    bank_rdata [NUM_BANKS];

  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_en[k]    = 1'b0;
      bank_we[k]    = 1'b0;
      bank_row[k]   = a_row;
      bank_wdata[k] = a_wdata;
      bank_be[k]    = a_be;
      if (a_fire && a_bank == BANK_W'(k)) begin
        bank_en[k] = 1'b1;
        bank_we[k] = a_we;
      end else if (b_fire && b_bank == BANK_W'(k)) begin
        bank_en[k]    = 1'b1;
        bank_we[k]    = b_we;
        bank_row[k]   = b_row;
        bank_wdata[k] = b_wdata;
        bank_be[k]    = b_be;
      end
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    sram_bank #(.WORD_W(WORD_W), .DEPTH(BANK_DEPTH)) u_bank (
      .clk_i   (clk),
      .en_i    (bank_en[k]),
      .we_i    (bank_we[k]),
      .row_i   (bank_row[k]),
      .wdata_i (bank_wdata[k]),
      .be_i    (bank_be[k]),
      .rdata_o (bank_rdata[k])
    );
  end

  logic              a_rvalid_q, b_rvalid_q;
  logic [BANK_W-1:0] a_sel_q, b_sel_q;
  logic [WORD_W-1:0] a_hold_q, b_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= PORT_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_sel_q    <= '0;
      b_sel_q    <= '0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      a_rvalid_q <= a_fire && !a_we;
      b_rvalid_q <= b_fire && !b_we;
      if (a_fire) a_sel_q <= a_bank;
      if (b_fire) b_sel_q <= b_bank;
      a_hold_q   <= a_rdata;
      b_hold_q   <= b_rdata;
    end
  end

  // Bank read registers can be reused by the other port, so hold a private copy.
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? bank_rdata[a_sel_q] : a_hold_q;
  assign b_rdata  = b_rvalid_q ? bank_rdata[b_sel_q] : b_hold_q;

endmodule

// File: tb/tb_sram_banked_dp.sv
// Directed self-checking bench for sram_banked_dp: default 4-bank build plus a
// single-bank 16-word build for the address-wrap case.
module tb_sram_banked_dp;

  localparam int AW  = 10;
  localparam int SAW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_valid, a_ready, a_we, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata, a_rdata;
  logic [3:0]    a_be;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata, b_rdata;
  logic [3:0]    b_be;

  logic           sa_valid, sa_ready, sa_we, sa_rvalid;
  logic [SAW-1:0] sa_addr;
  logic [31:0]    sa_wdata, sa_rdata;
  logic [3:0]     sa_be;
  logic           sb_valid, sb_ready, sb_we, sb_rvalid;
  logic [SAW-1:0] sb_addr;
  logic [31:0]    sb_wdata, sb_rdata;
  logic [3:0]     sb_be;

  int n_chk  = 0;
  int n_pass = 0;

  sram_banked_dp u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_be(a_be), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_be(b_be), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  sram_banked_dp #(.WORD_W(32), .BANK_DEPTH(16), .NUM_BANKS(1)) u_small (
    .clk(clk), .rst(rst),
    .a_valid(sa_valid), .a_ready(sa_ready), .a_we(sa_we), .a_addr(sa_addr),
    .a_wdata(sa_wdata), .a_be(sa_be), .a_rvalid(sa_rvalid), .a_rdata(sa_rdata),
    .b_valid(sb_valid), .b_ready(sb_ready), .b_we(sb_we), .b_addr(sb_addr),
    .b_wdata(sb_wdata), .b_be(sb_be), .b_rvalid(sb_rvalid), .b_rdata(sb_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
  endtask

  task automatic b_req(input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
  endtask

  task automatic sa_req(input logic we, input logic [SAW-1:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    sa_valid = 1'b1; sa_we = we; sa_addr = addr; sa_wdata = wdata; sa_be = be;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; sa_valid = 1'b0; sb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req(1'b0, 10'h005, 32'h0, 4'h0);
    b_req(1'b0, 10'h006, 32'h0, 4'h0);
    #1;
    n_chk++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready got %b want 0", a_ready); else n_pass++;
    n_chk++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready got %b want 0", b_ready); else n_pass++;
    tick(); tick();
    n_chk++; if (a_rvalid !== 1'b0) $display("FAIL rst_a_rvalid got %b want 0", a_rvalid); else n_pass++;
    n_chk++; if (a_rdata !== 32'h0) $display("FAIL rst_a_rdata got %h want 0", a_rdata); else n_pass++;
    n_chk++; if (b_rvalid !== 1'b0) $display("FAIL rst_b_rvalid got %b want 0", b_rvalid); else n_pass++;
    n_chk++; if (b_rdata !== 32'h0) $display("FAIL rst_b_rdata got %h want 0", b_rdata); else n_pass++;
    n_chk++; if (sa_rdata !== 32'h0) $display("FAIL rst_small_rdata got %h want 0", sa_rdata); else n_pass++;
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_basic();
    a_req(1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
    #1;
    n_chk++; if (a_ready !== 1'b1) $display("FAIL basic_wr_ready got %b want 1", a_ready); else n_pass++;
    tick();
    n_chk++; if (a_rvalid !== 1'b0) $display("FAIL basic_wr_no_rvalid got %b want 0", a_rvalid); else n_pass++;
    a_req(1'b0, 10'h005, 32'h0, 4'h0);
    tick();
    idle();
    n_chk++; if (a_rvalid !== 1'b1) $display("FAIL basic_rd_rvalid got %b want 1", a_rvalid); else n_pass++;
    n_chk++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL basic_rd_data got %h want deadbeef", a_rdata); else n_pass++;
    tick();
    n_chk++; if (a_rvalid !== 1'b0) $display("FAIL basic_rvalid_drop got %b want 0", a_rvalid); else n_pass++;
    n_chk++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL basic_rdata_hold got %h want deadbeef", a_rdata); else n_pass++;
  endtask

  task automatic test_byte_en();
    a_req(1'b1, 10'h009, 32'h11223344, 4'hF);
    tick();
    a_req(1'b1, 10'h009, 32'hAABBCCDD, 4'b0101);
    tick();
    a_req(1'b0, 10'h009, 32'h0, 4'h0);
    tick();
    n_chk++; if (a_rdata !== 32'h11BB33DD) $display("FAIL byte_en_merge got %h want 11bb33dd", a_rdata); else n_pass++;
    a_req(1'b1, 10'h009, 32'hFFFFFFFF, 4'h0);
    #1;
    n_chk++; if (a_ready !== 1'b1) $display("FAIL byte_en_be0_ready got %b want 1", a_ready); else n_pass++;
    tick();
    a_req(1'b0, 10'h009, 32'h0, 4'h0);
    tick();
    idle();
    n_chk++; if (a_rdata !== 32'h11BB33DD) $display("FAIL byte_en_be0_noop got %h want 11bb33dd", a_rdata); else n_pass++;
  endtask

  task automatic test_parallel();
    a_req(1'b1, 10'h004, 32'h0BADF00D, 4'hF);
    tick();
    a_req(1'b0, 10'h004, 32'h0, 4'h0);
    b_req(1'b1, 10'h005, 32'hCAFEF00D, 4'hF);
    #1;
    n_chk++; if (a_ready !== 1'b1) $display("FAIL par_a_ready got %b want 1", a_ready); else n_pass++;
    n_chk++; if (b_ready !== 1'b1) $display("FAIL par_b_ready got %b want 1", b_ready); else n_pass++;
    tick();
    idle();
    n_chk++; if (a_rdata !== 32'h0BADF00D || a_rvalid !== 1'b1) $display("FAIL par_a_rd got %b/%h want 1/0badf00d", a_rvalid, a_rdata); else n_pass++;
    n_chk++; if (b_rvalid !== 1'b0) $display("FAIL par_b_wr_no_rvalid got %b want 0", b_rvalid); else n_pass++;
    b_req(1'b0, 10'h005, 32'h0, 4'h0);
    tick();
    idle();
    n_chk++; if (b_rdata !== 32'hCAFEF00D || b_rvalid !== 1'b1) $display("FAIL par_b_rd got %b/%h want 1/cafef00d", b_rvalid, b_rdata); else n_pass++;
  endtask

  task automatic test_conflict();
    a_req(1'b1, 10'h002, 32'h22222222, 4'hF);
    tick();
    idle();
    b_req(1'b1, 10'h006, 32'h66666666, 4'hF);
    tick();
    a_req(1'b0, 10'h002, 32'h0, 4'h0);
    b_req(1'b0, 10'h006, 32'h0, 4'h0);
    #1;
    n_chk++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL cf1_grant got a=%b b=%b want a=1 b=0", a_ready, b_ready); else n_pass++;
    tick();
    n_chk++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h22222222 || b_rvalid !== 1'b0) $display("FAIL cf1_resp got a=%b/%h b=%b want 1/22222222 0", a_rvalid, a_rdata, b_rvalid); else n_pass++;
    #1;
    n_chk++; if (a_ready !== 1'b0 || b_ready !== 1'b1) $display("FAIL cf2_grant got a=%b b=%b want a=0 b=1", a_ready, b_ready); else n_pass++;
    tick();
    n_chk++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h66666666 || a_rvalid !== 1'b0) $display("FAIL cf2_resp got b=%b/%h a=%b want 1/66666666 0", b_rvalid, b_rdata, a_rvalid); else n_pass++;
    #1;
    n_chk++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL cf3_grant got a=%b b=%b want a=1 b=0", a_ready, b_ready); else n_pass++;
    tick();
    n_chk++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) $display("FAIL cf3_resp got a=%b b=%b want a=1 b=0", a_rvalid, b_rvalid); else n_pass++;
    b_valid = 1'b0;
    #1;
    n_chk++; if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL nocf_ready got a=%b b=%b want a=1 b=1", a_ready, b_ready); else n_pass++;
    tick();
    b_req(1'b0, 10'h006, 32'h0, 4'h0);
    #1;
    n_chk++; if (a_ready !== 1'b0 || b_ready !== 1'b1) $display("FAIL cf4_ptr_kept got a=%b b=%b want a=0 b=1", a_ready, b_ready); else n_pass++;
    tick();
    idle();
    n_chk++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h66666666) $display("FAIL cf4_resp got %b/%h want 1/66666666", b_rvalid, b_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_raw();
    a_req(1'b1, 10'h00C, 32'h12345678, 4'hF);
    tick();
    idle();
    b_req(1'b0, 10'h00C, 32'h0, 4'h0);
    tick();
    idle();
    n_chk++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h12345678) $display("FAIL raw_b_rd got %b/%h want 1/12345678", b_rvalid, b_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid();
    a_req(1'b0, 10'h005, 32'h0, 4'h0);
    b_req(1'b0, 10'h001, 32'h0, 4'h0);
    tick();
    idle();
    n_chk++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hCAFEF00D) $display("FAIL rmid_pre_rd got %b/%h want 1/cafef00d", a_rvalid, a_rdata); else n_pass++;
    rst = 1'b1;
    a_req(1'b1, 10'h005, 32'hFFFFFFFF, 4'hF);
    b_req(1'b0, 10'h004, 32'h0, 4'h0);
    #1;
    n_chk++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL rmid_ready got a=%b b=%b want 0 0", a_ready, b_ready); else n_pass++;
    tick();
    n_chk++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) $display("FAIL rmid_a_resp got %b/%h want 0/0", a_rvalid, a_rdata); else n_pass++;
    n_chk++; if (b_rvalid !== 1'b0) $display("FAIL rmid_b_no_resp got %b want 0", b_rvalid); else n_pass++;
    rst = 1'b0;
    a_req(1'b0, 10'h005, 32'h0, 4'h0);
    b_req(1'b0, 10'h001, 32'h0, 4'h0);
    #1;
    n_chk++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL rmid_ptr_reset got a=%b b=%b want 1 0", a_ready, b_ready); else n_pass++;
    tick();
    idle();
    n_chk++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hCAFEF00D) $display("FAIL rmid_wr_suppressed got %b/%h want 1/cafef00d", a_rvalid, a_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    sa_req(1'b1, 4'h0, 32'h00000AAA, 4'hF);
    tick();
    sa_req(1'b1, 4'hF, 32'hFFFF5555, 4'hF);
    tick();
    sa_req(1'b0, 4'hF, 32'h0, 4'h0);
    #1;
    n_chk++; if (sa_ready !== 1'b1) $display("FAIL wrap_ready got %b want 1", sa_ready); else n_pass++;
    tick();
    n_chk++; if (sa_rvalid !== 1'b1 || sa_rdata !== 32'hFFFF5555) $display("FAIL wrap_max_rd got %b/%h want 1/ffff5555", sa_rvalid, sa_rdata); else n_pass++;
    sa_req(1'b0, 4'h0, 32'h0, 4'h0);
    tick();
    idle();
    n_chk++; if (sa_rvalid !== 1'b1 || sa_rdata !== 32'h00000AAA) $display("FAIL wrap_zero_rd got %b/%h want 1/00000aaa", sa_rvalid, sa_rdata); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    sa_valid = 1'b0; sa_we = 1'b0; sa_addr = '0; sa_wdata = '0; sa_be = '0;
    sb_valid = 1'b0; sb_we = 1'b0; sb_addr = '0; sb_wdata = '0; sb_be = '0;
    test_reset();
    test_basic();
    test_byte_en();
    test_parallel();
    test_conflict();
    test_raw();
    test_reset_mid();
    test_wrap();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
